// File: rtl/hazard_controller_pkg.sv
// -----------------------------------------------------------------------------
// hazard_controller_pkg
//   Shared definitions for the five-stage pipeline hazard controller:
//   - FSM state encodings (RUN / MEM_WAIT / REDIRECT), exposed on ctrlState
//   - E-stage operand forward-select encodings
//   - register-index type
//   - fwdPick: priority select between E-M and M-W forwarding sources
// -----------------------------------------------------------------------------
package hazard_controller_pkg;

  // Controller FSM states (value visible on the ctrlState debug port)
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  // E-stage operand source select
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;

  typedef logic [3:0] regIdx_t;

  // The younger producer (in E) holds the newer value, so it wins over M.
  function automatic logic [1:0] fwdPick(input logic exHit, input logic memHit);
    if (exHit)       return FWD_EXMEM;
    else if (memHit) return FWD_MEMWB;
    else             return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/hazard_controller_compare.sv
// -----------------------------------------------------------------------------
// hazard_compare
//   Compares both decode-stage source indices against one destination index.
//   A match requires the source to be actually read; the destination's
//   write-enable is qualified by the caller because E and M use it differently.
//
//   Ports:
//     src1Idx, src2Idx  in  4  decode source register indices
//     src1Use, src2Use  in  1  source actually read
//     dstIdx            in  4  destination index of an older instruction
//     match1, match2    out 1  per-source index match
// -----------------------------------------------------------------------------
module hazard_compare
  import hazard_controller_pkg::*;
(
  input  regIdx_t src1Idx,
  input  regIdx_t src2Idx,
  input  logic    src1Use,
  input  logic    src2Use,
  input  regIdx_t dstIdx,
  output logic    match1,
  output logic    match2
);

  // Every index including r0 is compared; no register is treated as special.
  assign match1 = src1Use & (src1Idx == dstIdx);
  assign match2 = src2Use & (src2Idx == dstIdx);

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Drives enables and flushes of the PC and inter-stage registers of the
//   five-stage pipeline (F, D, E, M, W). Handles, in priority order:
//   reset > data-memory wait > redirect (branch/JAL in E) > RAW hazard > run.
//
//   Build option: HAZARD_FORWARD_EN
//     defined   - E-stage forwarding; only load-use stalls (1 bubble).
//     undefined - no forwarding; stall on any match against E or M dest,
//                 fwdSelA/B tied to the register file.
//
//   Parameters:
//     BR_PENALTY  0..7  extra cycles fetch output is discarded after redirect
//
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     decSrc1Idx/decSrc2Idx/..Use     decode-stage sources
//     exWrtIndex/exRegWrEn/exIsLoad   E-stage destination info
//     memWrtIndex/memRegWrEn          M-stage destination info
//     memIsLoad/memIsStore/memAck     M-stage memory access and completion
//     exBrTaken/exIsJal               redirect resolved in E
//     pcWrEn/fdWrEn/deWrEn/emWrEn     register enables
//     fdFlush/deFlush                 bubble insertion into F-D / D-E
//     fwdSelA/fwdSelB                 E operand select (registered)
//     ctrlState                       FSM state, debug
//
//   Handshake note: every enable and flush is a same-cycle combinational
//   decision; a register captures (or bubbles) on the rising edge where its
//   enable (or flush) is high. A flush takes effect together with its enable.
// -----------------------------------------------------------------------------
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int BR_PENALTY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  regIdx_t    decSrc1Idx,
  input  regIdx_t    decSrc2Idx,
  input  logic       decSrc1Use,
  input  logic       decSrc2Use,
  input  regIdx_t    exWrtIndex,
  input  logic       exRegWrEn,
  input  logic       exIsLoad,
  input  regIdx_t    memWrtIndex,
  input  logic       memRegWrEn,
  input  logic       memIsLoad,
  input  logic       memIsStore,
  input  logic       memAck,
  input  logic       exBrTaken,
  input  logic       exIsJal,
  output logic       pcWrEn,
  output logic       fdWrEn,
  output logic       deWrEn,
  output logic       emWrEn,
  output logic       fdFlush,
  output logic       deFlush,
  output logic [1:0] fwdSelA,
  output logic [1:0] fwdSelB,
  output logic [1:0] ctrlState
);

  localparam logic [2:0] REDIR_INIT = (BR_PENALTY > 0) ? 3'(BR_PENALTY - 1) : 3'd0;

  logic [1:0] state, stateNext;
  logic [2:0] redirCnt, redirCntNext;

  logic exMatch1, exMatch2, memMatch1, memMatch2;
  logic memWait, redirReq, inRedirect, stall;

  hazard_compare uCmpEx (
    .src1Idx (decSrc1Idx),
    .src2Idx (decSrc2Idx),
    .src1Use (decSrc1Use),
    .src2Use (decSrc2Use),
    .dstIdx  (exWrtIndex),
    .match1  (exMatch1),
    .match2  (exMatch2)
  );

  hazard_compare uCmpMem (
    .src1Idx (decSrc1Idx),
    .src2Idx (decSrc2Idx),
    .src1Use (decSrc1Use),
    .src2Use (decSrc2Use),
    .dstIdx  (memWrtIndex),
    .match1  (memMatch1),
    .match2  (memMatch2)
  );

  // A pending data access freezes everything; the ack cycle itself runs
  // normally, so any redirect or hazard held in E/D is re-evaluated then.
  assign memWait    = (memIsLoad | memIsStore) & ~memAck;
  assign redirReq   = exBrTaken | exIsJal;
  assign inRedirect = (state == ST_REDIRECT);

`ifdef HAZARD_FORWARD_EN
  // Only a load in E cannot be forwarded in time.
  assign stall = exRegWrEn & exIsLoad & (exMatch1 | exMatch2);
`else
  // Without forwarding, both a load and an ALU result in E must reach the
  // register file first, as must anything in M. W is covered by the register
  // file writing before it is read.
  logic exHit;
  assign exHit = exMatch1 | exMatch2;
  assign stall = (exRegWrEn & exIsLoad & exHit)
               | (exRegWrEn & ~exIsLoad & exHit)
               | (memRegWrEn & (memMatch1 | memMatch2));
`endif

  // Enable / flush decision
  always_comb begin
    pcWrEn  = 1'b1;
    fdWrEn  = 1'b1;
    deWrEn  = 1'b1;
    emWrEn  = 1'b1;
    fdFlush = 1'b0;
    deFlush = 1'b0;
    if (reset) begin
      pcWrEn  = 1'b0;
      fdWrEn  = 1'b0;
      deWrEn  = 1'b0;
      emWrEn  = 1'b0;
      fdFlush = 1'b1;
      deFlush = 1'b1;
    end else if (memWait) begin
      pcWrEn = 1'b0;
      fdWrEn = 1'b0;
      deWrEn = 1'b0;
      emWrEn = 1'b0;
    end else if (redirReq) begin
      // PC loads the target; both younger wrong-path instructions are squashed.
      fdFlush = 1'b1;
      deFlush = 1'b1;
    end else if (inRedirect) begin
      // Instruction memory is still returning wrong-path words; D holds a
      // bubble from the redirect, so no hazard check is needed here.
      fdFlush = 1'b1;
    end else if (stall) begin
      pcWrEn  = 1'b0;
      fdWrEn  = 1'b0;
      deFlush = 1'b1;
    end
  end

  // Next state
  always_comb begin
    stateNext    = ST_RUN;
    redirCntNext = redirCnt;
    if (memWait) begin
      stateNext = ST_MEM_WAIT;
    end else if (redirReq) begin
      // A redirect while already in REDIRECT restarts the count.
      if (BR_PENALTY > 0) begin
        stateNext    = ST_REDIRECT;
        redirCntNext = REDIR_INIT;
      end else begin
        stateNext    = ST_RUN;
        redirCntNext = 3'd0;
      end
    end else if (inRedirect) begin
      if (redirCnt == 3'd0) begin
        stateNext = ST_RUN;
      end else begin
        stateNext    = ST_REDIRECT;
        redirCntNext = redirCnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      redirCnt <= 3'd0;
    end else begin
      state    <= stateNext;
      redirCnt <= redirCntNext;
    end
  end

  assign ctrlState = state;

`ifdef HAZARD_FORWARD_EN
  // Operand selects travel with the instruction into E: captured when D-E
  // loads, zeroed with a bubble, held while D-E is frozen.
  logic [1:0] fwdA, fwdB;

  always_ff @(posedge clk) begin
    if (reset || deFlush) begin
      fwdA <= FWD_REGFILE;
      fwdB <= FWD_REGFILE;
    end else if (deWrEn) begin
      fwdA <= fwdPick(exMatch1 & exRegWrEn, memMatch1 & memRegWrEn);
      fwdB <= fwdPick(exMatch2 & exRegWrEn, memMatch2 & memRegWrEn);
    end
  end

  assign fwdSelA = fwdA;
  assign fwdSelB = fwdB;
`else
  assign fwdSelA = FWD_REGFILE;
  assign fwdSelB = FWD_REGFILE;
`endif

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Sequences the five-stage integer pipeline (F, D, E, M, W) by driving write-enables and flushes for the inter-stage pipeline registers. Detects read-after-write hazards between the instruction in decode and older in-flight instructions, squashes wrong-path instructions after a taken branch or JAL resolves in E, and freezes the pipeline while a data-memory access in M awaits acknowledge. Sits beside the pipeline registers; each register's enable/flush pins are driven from here.

## Interface
- BR_PENALTY, default 1: extra cycles fetch output is discarded after a redirect (instruction-memory refetch latency), range 0..7
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- decSrc1Idx / decSrc2Idx  in  4 each  decode-stage source register indices
- decSrc1Use / decSrc2Use  in  1 each  source actually read
- exWrtIndex, exRegWrEn, exIsLoad  in  4/1/1  destination info of instruction in E
- memWrtIndex, memRegWrEn  in  4/1  destination info of instruction in M
- memIsLoad, memIsStore  in  1/1  M holds a memory access
- memAck  in  1  data memory completes access this cycle
- exBrTaken, exIsJal  in  1/1  redirect resolved in E
- pcWrEn, fdWrEn, deWrEn, emWrEn  out  1 each  PC / F-D / D-E / E-M register enables
- fdFlush, deFlush  out  1 each  load bubble (RegWrEn/IsLoad/IsStore cleared) into F-D / D-E
- fwdSelA, fwdSelB  out  2 each  E-stage operand select: 0 regfile, 1 E-M aluOut, 2 M-W result
- ctrlState  out  2  FSM state, debug

## Operation
- States: RUN=0, MEM_WAIT=1, REDIRECT=2. Counter redirCnt, 3 bits.
- Priority per cycle: reset > memory wait > redirect > data hazard > normal.
- Memory wait: (memIsLoad|memIsStore)&!memAck -> all four enables 0, no flushes, state MEM_WAIT. E and D hold, so a pending redirect or hazard is re-evaluated after memAck. Cycle with memAck=1 behaves as RUN.
- Redirect: exBrTaken|exIsJal in RUN/REDIRECT, no memory wait -> pcWrEn=1 (target loads), fdFlush=1, deFlush=1, deWrEn=1, emWrEn=1. If BR_PENALTY>0, next state REDIRECT with redirCnt=BR_PENALTY-1; else RUN.
- REDIRECT: fdFlush=1, all enables 1; redirCnt decrements; leave to RUN when redirCnt==0. New redirect here restarts the count.
- Data hazard: matchX = decSrcXUse & idx equal; all 16 indices compared, none special.
- With forwarding: load-use stall only, i.e. match vs E dest with exRegWrEn&exIsLoad -> pcWrEn=0, fdWrEn=0, deFlush=1, deWrEn=1, emWrEn=1. One bubble per occurrence.
- Forward select registered on D->E advance: 1 if match vs E dest (exRegWrEn), else 2 if match vs M dest (memRegWrEn), else 0. Cleared to 0 on deFlush or reset; held when deWrEn=0.
- Redirect and load-use in same cycle: redirect wins, no stall.

## Timing
- Enables/flushes combinational from inputs and state; same-cycle effect.
- ctrlState, redirCnt, fwdSelA/B registered; update on the edge after decision.
- While reset=1: all enables 0, fdFlush=deFlush=1. After reset edge: state RUN, redirCnt=0, fwdSel=0.
- Reset mid-MEM_WAIT or mid-REDIRECT: RUN on next edge; no residual flush.
- Load-use penalty 1 cycle; redirect penalty 2+BR_PENALTY bubbles; memory wait N cycles for ack after N cycles.

## Configuration
- HAZARD_FORWARD_EN defined: forwarding as above.
- Undefined: fwdSelA/B tied 0; stall (pcWrEn=0, fdWrEn=0, deFlush=1) on any match vs E dest (exRegWrEn) or M dest (memRegWrEn); register file write-before-read covers W.

## Structure
- Shared package: state encodings, FWD_REGFILE/FWD_EXMEM/FWD_MEMWB constants, 4-bit register-index type.
- Sub-module hazard_compare: two sources vs one destination -> two match bits. Instantiated twice (E and M).

## Test plan
- Load r3 in E, decode reads r3 -> one cycle pcWrEn=0, deFlush=1; next cycle fwdSelA=2 on advance.
- ADD writes r5 in E, decode reads r5 on src2 (FORWARD_EN) -> no stall, fwdSelB=1 next edge; without macro -> stall 2 cycles.
- exBrTaken=1, BR_PENALTY=1 -> fdFlush=deFlush=1 that cycle, fdFlush=1 next, ctrlState 2 then 0.
- Store in M, memAck low 3 cycles with exBrTaken=1 -> all enables 0 for 3 cycles, redirect flush on ack cycle.
- Reset asserted in REDIRECT with redirCnt=2 -> ctrlState 0, fwdSel 0 after one edge.
